d2_uop_sequencer: RTL and testbench

Micro-op sequencer for decode stage 2. It selects the control-store address for each cycle: the decode address for a new instruction, or the latched next-micro-address for the successor uops of a multi-uop instruction. It holds state while AG stalls and aborts the sequence on an interrupt or a REPNE terminate. It replaces the ad-hoc sel_uop and next-address registers in front of the ucontrol_store pair.

---
 rtl/d2_uop_sequencer_if.sv | 39 +++
 rtl/d2_uop_sequencer.sv | 125 ++++++++++++
 tb/tb_d2_uop_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/d2_uop_sequencer_if.sv
// Bundle between decode stage 2 and the micro-op sequencer.
// master: the side that drives decode/AG/flush inputs and observes the
//         control-store address.
// slave:  the sequencer itself.
interface d2_uop_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int NEXT_W = 7,
  parameter int CNT_W  = 4
);
  logic              D2_V;
  logic              AG_STALL_OUT_LD_D2_IN;
  logic              INT_EXIST;
  logic              WB_REPNE_TERMINATE_ALL;
  logic [ADDR_W-1:0] decode_address;
  logic              opcode_size;
  logic              CS_UOP_STALL_DE;
  logic [NEXT_W-1:0] CS_NEXT_MICRO_ADDRESS_DE;
  logic [ADDR_W-1:0] control_store_address;
  logic              control_store_op_size;
  logic              D2_UOP_STALL_OUT;
  logic [CNT_W-1:0]  uop_index;
  logic              seq_busy;
  logic              seq_abort;
  logic              seq_overflow;

  modport master (
    output D2_V, AG_STALL_OUT_LD_D2_IN, INT_EXIST, WB_REPNE_TERMINATE_ALL,
           decode_address, opcode_size, CS_UOP_STALL_DE, CS_NEXT_MICRO_ADDRESS_DE,
    input  control_store_address, control_store_op_size, D2_UOP_STALL_OUT,
           uop_index, seq_busy, seq_abort, seq_overflow
  );

  modport slave (
    input  D2_V, AG_STALL_OUT_LD_D2_IN, INT_EXIST, WB_REPNE_TERMINATE_ALL,
           decode_address, opcode_size, CS_UOP_STALL_DE, CS_NEXT_MICRO_ADDRESS_DE,
    output control_store_address, control_store_op_size, D2_UOP_STALL_OUT,
           uop_index, seq_busy, seq_abort, seq_overflow
  );
endinterface

// File: rtl/d2_uop_sequencer.sv
// Decode-stage-2 micro-op sequencer.
// Picks the control-store address each cycle: the decoder's address for a
// new instruction (IDLE) or the latched successor address while walking a
// multi-uop instruction (SEQ). Holds on AG stall, aborts on interrupt or
// REPNE terminate.
// Optional build macro D2_UOP_WATCHDOG_EN: forces an exit and raises a sticky
// seq_overflow when a chain tries to go past uop index MAX_UOPS. Without it,
// uop_index simply wraps and seq_overflow is tied low.
module d2_uop_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int NEXT_W   = 7,
  parameter int CNT_W    = 4,
  parameter int MAX_UOPS = 15
) (
  input logic               clk,
  input logic               reset,
  d2_uop_sequencer_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, SEQ = 1'b1} state_t;

  // The largest legal index must be representable by the counter.
  if (MAX_UOPS > (2 ** CNT_W) - 1) begin : g_max_uops_range
    $error("MAX_UOPS does not fit in CNT_W bits");
  end

  state_t            state, state_n;
  logic [NEXT_W-1:0] next_addr, next_addr_n;
  logic [CNT_W-1:0]  uop_index, uop_index_n;
  logic              abort_q, abort_n;
  logic              overflow_q, overflow_n;
  logic              flush;
  logic              adv;

  assign flush = bus.INT_EXIST | bus.WB_REPNE_TERMINATE_ALL;
  assign adv   = bus.D2_V & bus.AG_STALL_OUT_LD_D2_IN;

  // State, successor address, index and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      next_addr  <= '0;
      uop_index  <= '0;
      abort_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state      <= state_n;
      next_addr  <= next_addr_n;
      uop_index  <= uop_index_n;
      abort_q    <= abort_n;
      overflow_q <= overflow_n;
    end
  end

  // Next-state logic and control-store address selection.
  always_comb begin
    state_n                   = state;
    next_addr_n               = next_addr;
    uop_index_n               = uop_index;
    abort_n                   = 1'b0;
    overflow_n                = overflow_q;
    bus.control_store_address = bus.decode_address;
    bus.control_store_op_size = bus.opcode_size;
    bus.D2_UOP_STALL_OUT      = bus.D2_V & bus.CS_UOP_STALL_DE & ~flush;

    case (state)
      IDLE: begin
        uop_index_n = '0;
        if (adv && bus.CS_UOP_STALL_DE && !flush) begin
          state_n     = SEQ;
          next_addr_n = bus.CS_NEXT_MICRO_ADDRESS_DE;
          uop_index_n = CNT_W'(1);
        end
      end
      SEQ: begin
        // Successor uops always use the 1-byte opcode half of the store.
        bus.control_store_address = ADDR_W'(next_addr);
        bus.control_store_op_size = 1'b0;
        if (flush) begin
          // Flush beats a same-cycle accept; report the kill next cycle.
          state_n     = IDLE;
          uop_index_n = '0;
          abort_n     = 1'b1;
        end else if (!adv) begin
          // AG stall or empty D2: everything holds, address stays stable.
          state_n = SEQ;
        end else if (bus.CS_UOP_STALL_DE) begin
`ifdef D2_UOP_WATCHDOG_EN
          if (uop_index == CNT_W'(MAX_UOPS)) begin
            // Runaway chain: bail out and latch the error until reset.
            state_n     = IDLE;
            uop_index_n = '0;
            overflow_n  = 1'b1;
          end else begin
            next_addr_n = bus.CS_NEXT_MICRO_ADDRESS_DE;
            uop_index_n = uop_index + CNT_W'(1);
          end
`else
          next_addr_n = bus.CS_NEXT_MICRO_ADDRESS_DE;
          uop_index_n = uop_index + CNT_W'(1);
`endif
        end else begin
          // Last uop of the instruction accepted.
          state_n     = IDLE;
          uop_index_n = '0;
        end
      end
      default: begin
        state_n     = IDLE;
        uop_index_n = '0;
      end
    endcase
  end

  assign bus.uop_index = uop_index;
  assign bus.seq_busy  = (state == SEQ);
  assign bus.seq_abort = abort_q;

`ifdef D2_UOP_WATCHDOG_EN
  assign bus.seq_overflow = overflow_q;
`else
  assign bus.seq_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_d2_uop_sequencer.sv
// Directed bench for d2_uop_sequencer: a cycle-by-cycle vector table plus
// hand-written sequences for async reset and long uop chains.
module tb_d2_uop_sequencer;

  logic clk;
  logic reset;

  d2_uop_sequencer_if #(.ADDR_W(8), .NEXT_W(7), .CNT_W(4)) bus ();

  d2_uop_sequencer #(.ADDR_W(8), .NEXT_W(7), .CNT_W(4), .MAX_UOPS(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       d2v;
    logic       ld;
    logic       intx;
    logic       rep;
    logic [7:0] dec;
    logic       ops;
    logic       stall;
    logic [6:0] nxt;
    logic [7:0] e_addr;
    logic       e_ops;
    logic       e_ustall;
    logic [3:0] e_idx;
    logic       e_busy;
    logic       e_abort;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic d2v, input logic ld, input logic intx,
                              input logic rep, input logic [7:0] dec, input logic ops,
                              input logic stall, input logic [6:0] nxt,
                              input logic [7:0] e_addr, input logic e_ops,
                              input logic e_ustall, input logic [3:0] e_idx,
                              input logic e_busy, input logic e_abort);
    vec_t v;
    v.d2v = d2v; v.ld = ld; v.intx = intx; v.rep = rep; v.dec = dec; v.ops = ops;
    v.stall = stall; v.nxt = nxt; v.e_addr = e_addr; v.e_ops = e_ops;
    v.e_ustall = e_ustall; v.e_idx = e_idx; v.e_busy = e_busy; v.e_abort = e_abort;
    return v;
  endfunction

  task automatic drive(input logic d2v, input logic ld, input logic intx, input logic rep,
                       input logic [7:0] dec, input logic ops, input logic stall,
                       input logic [6:0] nxt);
    bus.D2_V                     = d2v;
    bus.AG_STALL_OUT_LD_D2_IN    = ld;
    bus.INT_EXIST                = intx;
    bus.WB_REPNE_TERMINATE_ALL   = rep;
    bus.decode_address           = dec;
    bus.opcode_size              = ops;
    bus.CS_UOP_STALL_DE          = stall;
    bus.CS_NEXT_MICRO_ADDRESS_DE = nxt;
  endtask

  // Apply one vector after the falling edge and check the outputs it sees
  // before the next rising edge commits the cycle.
  task automatic apply(input int n, input vec_t v);
    logic [15:0] act, exp;
    @(negedge clk);
    drive(v.d2v, v.ld, v.intx, v.rep, v.dec, v.ops, v.stall, v.nxt);
    #1;
    act = {bus.control_store_address, bus.control_store_op_size, bus.D2_UOP_STALL_OUT,
           bus.uop_index, bus.seq_busy, bus.seq_abort};
    exp = {v.e_addr, v.e_ops, v.e_ustall, v.e_idx, v.e_busy, v.e_abort};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec%0d addr/ops/ustall/idx/busy/abort got %h/%b/%b/%0d/%b/%b want %h/%b/%b/%0d/%b/%b",
               n, bus.control_store_address, bus.control_store_op_size, bus.D2_UOP_STALL_OUT,
               bus.uop_index, bus.seq_busy, bus.seq_abort,
               v.e_addr, v.e_ops, v.e_ustall, v.e_idx, v.e_busy, v.e_abort);
    end
  endtask

  task automatic check1(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  logic       m_busy;
  logic [3:0] m_idx;
  logic       m_ovf;

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 8'h00, 0, 0, 7'h00);

    // Reset state
    #1;
    check1("rst_busy", {7'b0, bus.seq_busy}, 8'h00);
    check1("rst_idx", {4'b0, bus.uop_index}, 8'h00);
    check1("rst_abort", {7'b0, bus.seq_abort}, 8'h00);
    check1("rst_ovf", {7'b0, bus.seq_overflow}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // d2v ld int rep dec ops stall nxt | addr ops ustall idx busy abort
    // single uop
    vecs.push_back(mk(1,1,0,0,8'h3A,1,0,7'h00, 8'h3A,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,8'h10,0,0,7'h00, 8'h10,0,0,0,0,0));
    // three uops, no stalls
    vecs.push_back(mk(1,1,0,0,8'h3A,1,1,7'h41, 8'h3A,1,1,0,0,0));
    vecs.push_back(mk(1,1,0,0,8'h3A,1,1,7'h42, 8'h41,0,1,1,1,0));
    vecs.push_back(mk(1,1,0,0,8'h3A,1,0,7'h00, 8'h42,0,0,2,1,0));
    vecs.push_back(mk(0,0,0,0,8'h55,0,0,7'h00, 8'h55,0,0,0,0,0));
    // AG stall for 4 cycles at uop 1, then an empty-D2 cycle
    vecs.push_back(mk(1,1,0,0,8'h3A,1,1,7'h41, 8'h3A,1,1,0,0,0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1,0,0,0,8'h3A,1,1,7'h7F, 8'h41,0,1,1,1,0));
    vecs.push_back(mk(0,1,0,0,8'h3A,1,1,7'h7F, 8'h41,0,0,1,1,0));
    vecs.push_back(mk(1,1,0,0,8'h3A,1,1,7'h42, 8'h41,0,1,1,1,0));
    vecs.push_back(mk(1,1,0,0,8'h3A,1,0,7'h00, 8'h42,0,0,2,1,0));
    vecs.push_back(mk(0,0,0,0,8'h55,0,0,7'h00, 8'h55,0,0,0,0,0));
    // interrupt flush together with adv at uop 1
    vecs.push_back(mk(1,1,0,0,8'h3A,1,1,7'h41, 8'h3A,1,1,0,0,0));
    vecs.push_back(mk(1,1,1,0,8'h3A,1,1,7'h42, 8'h41,0,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,8'h20,1,0,7'h00, 8'h20,1,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,8'h20,1,0,7'h00, 8'h20,1,0,0,0,0));
    // REPNE terminate flush together with adv at uop 1
    vecs.push_back(mk(1,1,0,0,8'h3A,1,1,7'h41, 8'h3A,1,1,0,0,0));
    vecs.push_back(mk(1,1,0,1,8'h3A,1,1,7'h42, 8'h41,0,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,8'h21,0,0,7'h00, 8'h21,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,8'h21,0,0,7'h00, 8'h21,0,0,0,0,0));
    // flush in IDLE: no entry, no abort
    vecs.push_back(mk(1,1,1,0,8'h3A,1,1,7'h41, 8'h3A,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,8'h3A,0,0,7'h00, 8'h3A,0,0,0,0,0));
    // flush during an AG stall still aborts
    vecs.push_back(mk(1,1,0,0,8'h3A,1,1,7'h41, 8'h3A,1,1,0,0,0));
    vecs.push_back(mk(1,0,0,1,8'h3A,1,1,7'h00, 8'h41,0,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,8'h11,0,0,7'h00, 8'h11,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,8'h11,0,0,7'h00, 8'h11,0,0,0,0,0));

    foreach (vecs[i]) apply(i, vecs[i]);

    // Async reset at uop 2: takes effect before the next rising edge.
    apply(100, mk(1,1,0,0,8'h3A,1,1,7'h41, 8'h3A,1,1,0,0,0));
    apply(101, mk(1,1,0,0,8'h3A,1,1,7'h42, 8'h41,0,1,1,1,0));
    apply(102, mk(1,0,0,0,8'h3A,1,1,7'h43, 8'h42,0,1,2,1,0));
    reset = 1'b1;
    #1;
    check1("arst_busy", {7'b0, bus.seq_busy}, 8'h00);
    check1("arst_idx", {4'b0, bus.uop_index}, 8'h00);
    check1("arst_addr", bus.control_store_address, 8'h3A);
    reset = 1'b0;
    drive(0, 0, 0, 0, 8'h3A, 0, 0, 7'h00);
    @(posedge clk);
    #1;
    check1("arst_noabort", {7'b0, bus.seq_abort}, 8'h00);
    check1("arst_idle", {7'b0, bus.seq_busy}, 8'h00);

    // 17-uop chain: wraps by default, forced exit with the watchdog.
    m_busy = 1'b0;
    m_idx  = 4'd0;
    m_ovf  = 1'b0;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      drive(1, 1, 0, 0, 8'h3A, 0, 1, 7'(k + 1));
      #1;
      check1($sformatf("chain%0d_idx", k), {4'b0, bus.uop_index}, {4'b0, m_idx});
      check1($sformatf("chain%0d_busy", k), {7'b0, bus.seq_busy}, {7'b0, m_busy});
`ifdef D2_UOP_WATCHDOG_EN
      if (m_busy && m_idx == 4'd15) begin
        m_busy = 1'b0;
        m_idx  = 4'd0;
        m_ovf  = 1'b1;
      end else if (!m_busy) begin
        m_busy = 1'b1;
        m_idx  = 4'd1;
      end else begin
        m_idx = m_idx + 4'd1;
      end
`else
      if (!m_busy) begin
        m_busy = 1'b1;
        m_idx  = 4'd1;
      end else begin
        m_idx = m_idx + 4'd1;
      end
`endif
    end
    @(negedge clk);
    drive(1, 1, 0, 0, 8'h3A, 0, 0, 7'h00);
    #1;
    check1("chain_last_idx", {4'b0, bus.uop_index}, {4'b0, m_idx});
    check1("chain_ovf", {7'b0, bus.seq_overflow}, {7'b0, m_ovf});
    @(negedge clk);
    drive(0, 0, 0, 0, 8'h3A, 0, 0, 7'h00);
    #1;
    check1("chain_end_busy", {7'b0, bus.seq_busy}, 8'h00);
    check1("chain_ovf_sticky", {7'b0, bus.seq_overflow}, {7'b0, m_ovf});
    reset = 1'b1;
    #1;
    check1("ovf_cleared", {7'b0, bus.seq_overflow}, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
